// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use bubbles, data-memory wait freezes,
// taken-branch flushes, a saturating stall counter and a sticky memory timeout flag.
module hazard_stall_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IdEx_MemRead,
    input  logic [4:0]       IdEx_Rd,
    input  logic [4:0]       IfId_Rn,
    input  logic [4:0]       IfId_Rm,
    input  logic             IfId_useRm,
    input  logic             ExMem_MemAccess,
    input  logic             dmem_ready,
    input  logic             br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_err
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t           state_q;
    logic [WW-1:0]    wait_q;
    logic [CNT_W-1:0] stall_q;
    logic             err_q;

    logic load_use;
    logic mem_stall;

    // X31 is the zero register, so a load targeting it never creates a dependency.
    assign load_use  = IdEx_MemRead && (IdEx_Rd != 5'd31) &&
                       ((IdEx_Rd == IfId_Rn) || (IfId_useRm && (IdEx_Rd == IfId_Rm)));
    assign mem_stall = ExMem_MemAccess && !dmem_ready;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                    end else if (br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // The ready cycle advances with plain defaults; branches are ignored.
                    if (!dmem_ready) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                    end
                end
                default: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_q <= MEM_WAIT;
                        wait_q  <= WW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (wait_q == WW'(TIMEOUT - 1)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                default: begin
                    state_q <= ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign stall_count = stall_q;
    assign mem_err     = err_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed bench for hazard_stall_controller; two instances with
// different TIMEOUT/CNT_W are checked every cycle against a rule-level model.
module tb_hazard_stall_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, IdEx_MemRead, IfId_useRm, ExMem_MemAccess, dmem_ready, br_taken;
    logic [4:0] IdEx_Rd, IfId_Rn, IfId_Rm;

    logic       a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf, a_err;
    logic [1:0] a_cnt;
    logic       b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf, b_err;
    logic [7:0] b_cnt;

    hazard_stall_controller #(.TIMEOUT(4), .CNT_W(2)) u_a (
        .clk(clk), .reset(reset), .IdEx_MemRead(IdEx_MemRead), .IdEx_Rd(IdEx_Rd),
        .IfId_Rn(IfId_Rn), .IfId_Rm(IfId_Rm), .IfId_useRm(IfId_useRm),
        .ExMem_MemAccess(ExMem_MemAccess), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .pc_write(a_pcw), .ifid_write(a_ifw), .idex_write(a_idw), .exmem_write(a_exw),
        .ifid_flush(a_iff), .idex_flush(a_idf), .stall_count(a_cnt), .mem_err(a_err));

    hazard_stall_controller #(.TIMEOUT(7), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .IdEx_MemRead(IdEx_MemRead), .IdEx_Rd(IdEx_Rd),
        .IfId_Rn(IfId_Rn), .IfId_Rm(IfId_Rm), .IfId_useRm(IfId_useRm),
        .ExMem_MemAccess(ExMem_MemAccess), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .pc_write(b_pcw), .ifid_write(b_ifw), .idex_write(b_idw), .exmem_write(b_exw),
        .ifid_flush(b_iff), .idex_flush(b_idf), .stall_count(b_cnt), .mem_err(b_err));

    int checks = 0;
    int fails  = 0;

    // Model: waiting = number of not-ready cycles seen in the current access (0 = none).
    int TO[2] = '{4, 7};
    int MX[2] = '{3, 255};
    int waiting[2];
    int cnt[2];
    bit err[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {pc, ifid, idex, exmem, ifid_flush, idex_flush}
    function automatic logic [5:0] exp_out(input int k);
        bit lu;
        lu = IdEx_MemRead && IdEx_Rd != 5'd31 &&
             (IdEx_Rd == IfId_Rn || (IfId_useRm && IdEx_Rd == IfId_Rm));
        if (!reset)                           return 6'b000000;
        if (err[k])                           return 6'b000000;
        if (waiting[k] > 0)                   return dmem_ready ? 6'b111100 : 6'b000000;
        if (ExMem_MemAccess && !dmem_ready)   return 6'b000000;
        if (br_taken)                         return 6'b111111;
        if (lu)                               return 6'b001101;
        return 6'b111100;
    endfunction

    task automatic step();
        logic [5:0] e[2];
        #1;
        for (int k = 0; k < 2; k++) e[k] = exp_out(k);
        chk("a_ctl", {a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf}, e[0]);
        chk("a_cnt", a_cnt, cnt[0]);
        chk("a_err", a_err, err[0]);
        chk("b_ctl", {b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf}, e[1]);
        chk("b_cnt", b_cnt, cnt[1]);
        chk("b_err", b_err, err[1]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                waiting[k] = 0; cnt[k] = 0; err[k] = 0;
            end else begin
                if (!e[k][5] && cnt[k] < MX[k]) cnt[k]++;
                if (!err[k]) begin
                    if (waiting[k] > 0) begin
                        if (dmem_ready)                  waiting[k] = 0;
                        else if (waiting[k] == TO[k] - 1) err[k] = 1;
                        else                             waiting[k]++;
                    end else if (ExMem_MemAccess && !dmem_ready) begin
                        waiting[k] = 1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b1; IdEx_MemRead = 0; IdEx_Rd = 0; IfId_Rn = 1; IfId_Rm = 2;
        IfId_useRm = 0; ExMem_MemAccess = 0; dmem_ready = 0; br_taken = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b0; step(); reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin waiting[k] = 0; cnt[k] = 0; err[k] = 0; end
        @(posedge clk); @(negedge clk);

        do_reset();
        step();
        chk("rst_cnt", b_cnt, 0);

        // load-use on Rn: one bubble
        IdEx_MemRead = 1; IdEx_Rd = 5; IfId_Rn = 5; step();
        idle(); step();
        chk("lu_cnt", b_cnt, 1);

        // X31 and masked Rm never stall
        IdEx_MemRead = 1; IdEx_Rd = 31; IfId_Rn = 31; step();
        IdEx_Rd = 7; IfId_Rn = 0; IfId_Rm = 7; IfId_useRm = 0; step();
        IfId_useRm = 1; step();
        idle(); step();
        chk("rm_cnt", b_cnt, 2);

        // three not-ready cycles, advance on the fourth
        ExMem_MemAccess = 1;
        repeat (3) step();
        dmem_ready = 1; step();
        idle(); step();
        chk("mw_cnt", b_cnt, 5);
        chk("mw_sat", a_cnt, 3);

        // branch beats load-use; memory wait beats branch
        br_taken = 1; IdEx_MemRead = 1; IdEx_Rd = 5; IfId_Rn = 5; step();
        ExMem_MemAccess = 1; dmem_ready = 0; step();
        step();
        dmem_ready = 1; step();
        idle(); step();

        // timeout on instance a
        do_reset();
        ExMem_MemAccess = 1;
        repeat (4) step();
        chk("to_err_a", a_err, 1);
        chk("to_err_b", b_err, 0);
        dmem_ready = 1; repeat (2) step();
        chk("err_hold", a_err, 1);
        chk("err_pc", a_pcw, 0);

        // ready on the boundary cycle wins
        do_reset();
        ExMem_MemAccess = 1;
        repeat (3) step();
        dmem_ready = 1; step();
        idle(); step();
        chk("to_ready", a_err, 0);

        // reset mid-wait, then saturation
        ExMem_MemAccess = 1; repeat (2) step();
        reset = 0; step();
        idle(); step();
        chk("mid_rst_cnt", a_cnt, 0);
        IdEx_MemRead = 1; IdEx_Rd = 3; IfId_Rn = 3;
        repeat (5) step();
        chk("sat_cnt", a_cnt, 3);
        idle(); do_reset();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            reset           = ($urandom_range(0, 199) != 0);
            IdEx_MemRead    = ($urandom_range(0, 1) == 1);
            IdEx_Rd         = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            IfId_Rn         = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            IfId_Rm         = 5'($urandom_range(0, 3));
            IfId_useRm      = ($urandom_range(0, 1) == 1);
            ExMem_MemAccess = ($urandom_range(0, 2) == 0);
            dmem_ready      = ($urandom_range(0, 9) < 6);
            br_taken        = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
